// File: rtl/i2c_master_writer.sv
// I2C single-byte register writer (master, write-only, single-master bus).
// Sends START, {dev_addr,W}, reg_addr, wdata (MSB first, ACK slot after each byte), then STOP.
// A NACK on any byte skips the rest and goes straight to STOP with ack_error set.
// Optional build macro I2C_MASTER_STRETCH_EN: honour slave clock stretching via scl_in.
module i2c_master_writer #(
    parameter int unsigned CLK_DIV = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop} state_e;

    localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        nack_q, nack_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic qtr_end;
    logic freeze;
    logic tick;

`ifdef I2C_MASTER_STRETCH_EN
    // Slave holding SCL low while we release it pauses the quarter counter.
    assign freeze = !scl_in &&
                    (((state_q == StBit || state_q == StAck) && qtr_q[1]) ||
                     (state_q == StStop && qtr_q == 2'd1));
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign freeze        = 1'b0;
`endif

    assign qtr_end = (div_q == DivLast);
    assign tick    = (state_q != StIdle) && !freeze;

    // State register: all sequential state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sr_q      <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sr_q      <= sr_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Next-state logic: accept requests, step quarters, walk bits/bytes, sample ACK.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sr_d      = sr_q;
        reg_d     = reg_q;
        data_d    = data_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;

        if (state_q == StIdle) begin
            if (start) begin
                state_d   = StStart;
                div_d     = '0;
                qtr_d     = '0;
                bit_d     = 3'd7;
                byte_d    = '0;
                sr_d      = {dev_addr, 1'b0};
                reg_d     = reg_addr;
                data_d    = wdata;
                nack_d    = 1'b0;
                ack_err_d = 1'b0;
            end
        end else if (tick) begin
            if (!qtr_end) begin
                div_d = div_q + 16'd1;
            end else begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
                unique case (state_q)
                    StStart: begin
                        if (qtr_q == 2'd1) begin
                            state_d = StBit;
                            qtr_d   = '0;
                        end
                    end
                    StBit: begin
                        if (qtr_q == 2'd3) begin
                            if (bit_q == 3'd0) begin
                                state_d = StAck;
                            end else begin
                                bit_d = bit_q - 3'd1;
                                sr_d  = {sr_q[6:0], 1'b0};
                            end
                        end
                    end
                    StAck: begin
                        // Last cycle of Q3: SCL has been high for a full quarter.
                        if (qtr_q == 2'd2) begin
                            nack_d = sda_in;
                        end
                        if (qtr_q == 2'd3) begin
                            if (nack_q || byte_q == 2'd2) begin
                                state_d = StStop;
                            end else begin
                                state_d = StBit;
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                sr_d    = (byte_q == 2'd0) ? reg_q : data_q;
                            end
                        end
                    end
                    StStop: begin
                        if (qtr_q == 2'd2) begin
                            state_d   = StIdle;
                            qtr_d     = '0;
                            ack_err_d = nack_q;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Output decode from next state so every output comes straight from a flop.
    always_comb begin
        busy_d   = (state_d != StIdle);
        done_d   = (state_q == StStop) && (state_d == StIdle);
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        unique case (state_d)
            StIdle: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
            StStart: begin
                sda_oe_d = (qtr_d == 2'd1);
            end
            StBit: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !sr_d[7];
            end
            StAck: begin
                scl_oe_d = !qtr_d[1];
            end
            StStop: begin
                scl_oe_d = (qtr_d == 2'd0);
                sda_oe_d = (qtr_d != 2'd2);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Directed bench for i2c_master_writer with an open-drain bus slave/monitor model.
// Positions are counted in clk edges after the accepting edge T0; outputs are sampled 1ns later.
module tb_i2c_master_writer;

    localparam int unsigned CLK_DIV = 30;
    localparam int FULL = 113 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_error, scl_oe, sda_oe;
    logic       scl_in, sda_in;
    logic       ack_drive = 1'b0;
    logic       stretch_hold = 1'b0;

    int total = 0;
    int bad = 0;
    int pos = 0;
    int lat;

    // Bus monitor / slave state
    int         starts = 0;
    int         stops = 0;
    int         bitn = 0;
    int         rx_count = 0;
    int         nack_byte = 3;
    logic [7:0] rx [0:2];
    logic [7:0] cur = '0;

    assign scl_in = ~scl_oe & ~stretch_hold;
    assign sda_in = ~sda_oe & ~ack_drive;

    i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .scl_in    (scl_in),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    initial forever #5 clk = ~clk;

    // Slave + protocol monitor: decodes START/STOP, bits on SCL rise, drives ACK.
    initial begin
        logic p_scl, p_sda, scl_l, sda_l;
        p_scl = 1'b1;
        p_sda = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            scl_l = ~scl_oe;
            sda_l = ~sda_oe & ~ack_drive;
            if (p_scl && scl_l && p_sda && !sda_l) begin
                starts++;
                bitn     = 0;
                rx_count = 0;
            end else if (p_scl && scl_l && !p_sda && sda_l) begin
                stops++;
            end else if (!p_scl && scl_l) begin
                if (bitn % 9 < 8) begin
                    cur = {cur[6:0], sda_l};
                    if (bitn % 9 == 7 && rx_count < 3) begin
                        rx[rx_count] = cur;
                        rx_count++;
                    end
                end
                bitn++;
            end else if (p_scl && !scl_l) begin
                ack_drive = (bitn % 9 == 8) && ((bitn / 9) != nack_byte);
            end
            if (!busy) ack_drive = 1'b0;
            p_scl = scl_l;
            p_sda = ~sda_oe & ~ack_drive;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pos++;
        end
    endtask

    // Present a request and let edge T0 accept it; leaves start high if hold is set.
    task automatic launch(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                          input bit hold);
        starts   = 0;
        stops    = 0;
        rx_count = 0;
        dev_addr = d;
        reg_addr = r;
        wdata    = w;
        start    = 1'b1;
        @(posedge clk);
        #1;
        pos = 0;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        while (!done && pos < 5000) tick(1);
        edges = pos;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackerr", ack_error, 0);
        check("rst_scl", scl_oe, 0);
        check("rst_sda", sda_oe, 0);
        rst_n = 1'b1;
        tick(2);

        // All bytes ACKed: 0x42/0x03/0x80 -> 0x84,0x03,0x80
        nack_byte = 3;
        launch(7'h42, 8'h03, 8'h80, 1'b0);
        check("a_busy_t0p1", busy, 1);
        check("a_start_q1_sda", sda_oe, 0);
        tick(30);
        check("a_start_q2_sda", sda_oe, 1);
        check("a_start_q2_scl", scl_oe, 0);
        tick(30);
        check("a_b7_q1_scl", scl_oe, 1);
        check("a_b7_q1_sda", sda_oe, 0);
        tick(60);
        check("a_b7_q3_scl", scl_oe, 0);
        tick(60);
        check("a_b6_q1_sda", sda_oe, 1);
        wait_done(lat);
        check("a_latency", lat, FULL);
        check("a_done", done, 1);
        check("a_busy_end", busy, 0);
        check("a_ackerr", ack_error, 0);
        check("a_rx_count", rx_count, 3);
        check("a_rx0", rx[0], 8'h84);
        check("a_rx1", rx[1], 8'h03);
        check("a_rx2", rx[2], 8'h80);
        check("a_starts", starts, 1);
        check("a_stops", stops, 1);
        check("a_lines_idle", {scl_oe, sda_oe}, 2'b00);
        tick(1);
        check("a_done_pulse", done, 0);

        // NACK on address byte: STOP right after the 9th slot
        nack_byte = 0;
        launch(7'h42, 8'h03, 8'h80, 1'b0);
        wait_done(lat);
        check("n_latency", lat, (2 + 36 + 3) * CLK_DIV);
        check("n_done", done, 1);
        check("n_ackerr", ack_error, 1);
        check("n_rx_count", rx_count, 1);
        check("n_rx0", rx[0], 8'h84);
        check("n_stops", stops, 1);
        tick(5);
        check("n_ackerr_held", ack_error, 1);

        // start held high, inputs change mid-flight: original bytes, re-accept at done
        nack_byte = 3;
        launch(7'h42, 8'h5A, 8'hC3, 1'b1);
        check("h_ackerr_clr", ack_error, 0);
        tick(100);
        dev_addr = 7'h11;
        reg_addr = 8'h22;
        wdata    = 8'h33;
        wait_done(lat);
        check("h_latency", lat, FULL);
        check("h_rx0", rx[0], 8'h84);
        check("h_rx1", rx[1], 8'h5A);
        check("h_rx2", rx[2], 8'hC3);
        check("h_starts", starts, 1);
        tick(1);
        start = 1'b0;
        pos   = 0;
        starts = 0;
        stops  = 0;
        check("h_reaccept_busy", busy, 1);
        check("h_reaccept_done", done, 0);
        wait_done(lat);
        check("h2_latency", lat, FULL);
        check("h2_rx0", rx[0], 8'h22);
        check("h2_rx1", rx[1], 8'h22);
        check("h2_rx2", rx[2], 8'h33);
        check("h2_stops", stops, 1);
        tick(2);

        // Reset mid-transaction: lines released at once, no done pulse
        launch(7'h42, 8'h03, 8'h80, 1'b0);
        tick(999);
        rst_n = 1'b0;
        tick(1);
        check("r_scl", scl_oe, 0);
        check("r_sda", sda_oe, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            repeat (200) begin
                tick(1);
                if (done) seen = 1'b1;
            end
            check("r_no_done", seen, 0);
        end

`ifdef I2C_MASTER_STRETCH_EN
        // Slave stretches SCL for 100 cycles in Q3 of the 4th bit of the register byte
        nack_byte = 3;
        launch(7'h42, 8'h03, 8'h80, 1'b0);
        tick((38 + 12 + 2) * CLK_DIV);
        stretch_hold = 1'b1;
        tick(100);
        stretch_hold = 1'b0;
        wait_done(lat);
        check("s_latency", lat, FULL + 100);
        check("s_rx0", rx[0], 8'h84);
        check("s_rx1", rx[1], 8'h03);
        check("s_rx2", rx[2], 8'h80);
        check("s_ackerr", ack_error, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
